// File: rtl/eu_pkg.sv
// eu_pkg: definitions shared by the execution-unit command front end.
//   - opcode constants (MUL, DIV, highest legal opcode)
//   - dispatcher FSM state enum
//   - result width
package eu_pkg;

    localparam int RES_W = 16;

    localparam logic [3:0] OP_MUL       = 4'h8;
    localparam logic [3:0] OP_DIV       = 4'h9;
    localparam logic [3:0] OP_MAX_LEGAL = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } eu_state_e;

endpackage

// File: rtl/eu_cmd_fifo.sv
// eu_cmd_fifo: small synchronous command FIFO for eu_dispatch.
//   clk, rst   : clock and synchronous active-high reset (empties the FIFO)
//   push_i     : write wdata_i (ignored while full_o)
//   wdata_i    : packed command {opcode, a, b, tag}
//   pop_i      : discard the head entry (ignored while empty_o)
//   rdata_o    : head entry, valid whenever empty_o is low
//   full_o     : no free entry
//   empty_o    : no stored entry
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the pointers alone. The head is read combinationally so the
// dispatcher can load it in the same cycle it decides to pop.
module eu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
                    mem_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/eu_dispatch.sv
// eu_dispatch: command front end for the execution unit.
// Buffers commands in eu_cmd_fifo, issues one at a time with a single-cycle
// eu_start pulse, holds opcode/operands stable until eu_done (or timeout),
// then presents result, tag and error flag on a valid/ready response port.
//   cmd_*      : command input (valid/ready), opcode, operands, tag
//   eu_start   : one-cycle start pulse; eu_opcode/eu_a/eu_b held ISSUE..WAIT
//   eu_busy    : unit busy, blocks a new issue (covers ops orphaned by reset)
//   eu_done    : done pulse, eu_result sampled only then and only in WAIT
//   rsp_*      : response output (valid/ready), result, tag, error flag
// Optional feature macro DIVZERO_TRAP_EN: when defined, DIV with b=0 is
// answered locally with an error instead of being issued.
module eu_dispatch
    import eu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             eu_start,
    output logic [3:0]       eu_opcode,
    output logic [7:0]       eu_a,
    output logic [7:0]       eu_b,
    input  logic             eu_busy,
    input  logic             eu_done,
    input  logic [RES_W-1:0] eu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    localparam int FW    = 4 + 8 + 8 + TAG_W;
    localparam int TMR_W = $clog2(TIMEOUT);

    eu_state_e          state_q, state_d;
    logic [3:0]         op_opcode_q, op_opcode_d;
    logic [7:0]         op_a_q, op_a_d;
    logic [7:0]         op_b_q, op_b_d;
    logic [TAG_W-1:0]   op_tag_q, op_tag_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               err_q, err_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic [FW-1:0]      fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [3:0]         h_op;
    logic [7:0]         h_a;
    logic [7:0]         h_b;
    logic [TAG_W-1:0]   h_tag;
    logic               h_trap;

    eu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .wdata_i ({cmd_opcode, cmd_a, cmd_b, cmd_tag}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign {h_op, h_a, h_b, h_tag} = fifo_rdata;

    // Head commands answered locally with an error instead of being issued.
`ifdef DIVZERO_TRAP_EN
    assign h_trap = (h_op > OP_MAX_LEGAL) || ((h_op == OP_DIV) && (h_b == 8'd0));
`else
    assign h_trap = (h_op > OP_MAX_LEGAL);
`endif

    assign pop = (state_q == ST_IDLE) && !fifo_empty && !eu_busy;

    always_comb begin
        state_d     = state_q;
        op_opcode_d = op_opcode_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_tag_d    = op_tag_q;
        res_d       = res_q;
        err_d       = err_q;
        timer_d     = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    op_opcode_d = h_op;
                    op_a_d      = h_a;
                    op_b_d      = h_b;
                    op_tag_d    = h_tag;
                    if (h_trap) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (eu_done) begin
                    res_d   = eu_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    // Timer counts WAIT cycles from 0, so this leaves WAIT
                    // after exactly TIMEOUT cycles.
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_opcode_q <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_tag_q    <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_opcode_q <= op_opcode_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_tag_q    <= op_tag_d;
            res_q       <= res_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
        end
    end

    assign eu_start   = (state_q == ST_ISSUE);
    assign eu_opcode  = op_opcode_q;
    assign eu_a       = op_a_q;
    assign eu_b       = op_b_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = res_q;
    assign rsp_tag    = op_tag_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_eu_dispatch.sv
// tb_eu_dispatch: self-checking bench for eu_dispatch with a behavioural
// execution-unit model and a queue-based scoreboard of expected issues and
// responses. Honours DIVZERO_TRAP_EN the same way the design does.
module tb_eu_dispatch;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode = '0;
    logic [7:0]       cmd_a = '0;
    logic [7:0]       cmd_b = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic             eu_start;
    logic [3:0]       eu_opcode;
    logic [7:0]       eu_a;
    logic [7:0]       eu_b;
    logic             eu_busy;
    logic             eu_done;
    logic [15:0]      eu_result;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [15:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    eu_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .eu_start(eu_start), .eu_opcode(eu_opcode), .eu_a(eu_a), .eu_b(eu_b),
        .eu_busy(eu_busy), .eu_done(eu_done), .eu_result(eu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- execution unit behaviour ----------------
    function automatic logic [15:0] eu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd8:    return a * b;
            4'd9:    return (b == 8'd0) ? 16'hFFFF : {8'h00, a / b};
            default: return {a ^ b, op, 4'h5};
        endcase
    endfunction

    // The model unit never reports done for this operation.
    function automatic bit is_hang(input logic [3:0] op, input logic [7:0] a);
        return (op == 4'd7) && (a == 8'hEE);
    endfunction

    int eu_lat = 1;
    bit eu_lat_rand = 0;
    int done_cyc = -1;
    int busy_fall_cyc = -1;

    initial begin
        bit st, hang;
        logic [3:0] sop;
        logic [7:0] sa, sb;
        logic [15:0] res;
        int cnt, lat;
        cnt = 0; lat = 1; hang = 0; res = '0;
        eu_busy = 1'b0; eu_done = 1'b0; eu_result = '0;
        forever begin
            @(negedge clk);
            st = eu_start; sop = eu_opcode; sa = eu_a; sb = eu_b;
            @(posedge clk); #1;
            eu_done = 1'b0;
            eu_result = 16'($urandom);
            if (st) begin
                lat  = eu_lat_rand ? int'($urandom_range(1, 8)) : eu_lat;
                cnt  = 1;
                hang = is_hang(sop, sa);
                res  = eu_fn(sop, sa, sb);
            end else if (cnt > 0) begin
                cnt++;
            end
            if (cnt > 0) begin
                if (cnt >= lat) begin
                    if (eu_busy) busy_fall_cyc = cyc;
                    eu_busy = 1'b0;
                    if (!hang) begin
                        eu_done = 1'b1;
                        eu_result = res;
                        done_cyc = cyc;
                    end
                    cnt = 0;
                end else begin
                    eu_busy = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [15:0] res; logic [TAG_W-1:0] tag; logic err; } rsp_t;
    typedef struct { logic [3:0] op; logic [7:0] a; logic [7:0] b; } iss_t;
    rsp_t exp_q[$];
    iss_t iss_q[$];
    logic [TAG_W-1:0] tag_log[$];

    function automatic void model_accept(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [TAG_W-1:0] tag);
        bit trapped;
        rsp_t r;
        iss_t i;
        trapped = (op > 4'd9);
`ifdef DIVZERO_TRAP_EN
        if (op == 4'd9 && b == 8'd0) trapped = 1'b1;
`endif
        r.tag = tag;
        if (trapped) begin
            r.res = '0; r.err = 1'b1;
        end else begin
            i.op = op; i.a = a; i.b = b;
            iss_q.push_back(i);
            if (is_hang(op, a)) begin
                r.res = '0; r.err = 1'b1;
            end else begin
                r.res = eu_fn(op, a, b); r.err = 1'b0;
            end
        end
        exp_q.push_back(r);
    endfunction

    int   start_cnt = 0;
    int   last_start_cyc = -1;
    int   prev_start_cyc = -1000;
    bit   inflight = 0;
    iss_t held;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                inflight = 0;
                continue;
            end
            if (cmd_valid && cmd_ready) model_accept(cmd_opcode, cmd_a, cmd_b, cmd_tag);
            if (eu_start) begin
                start_cnt++;
                chk("start_while_busy", 32'(eu_busy), 32'd0);
                chk("start_spacing_ge4", 32'((cyc - prev_start_cyc) >= 4), 32'd1);
                prev_start_cyc = cyc;
                last_start_cyc = cyc;
                if (iss_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_start actual=start required=no_start (cycle %0d)", cyc);
                end else begin
                    held = iss_q.pop_front();
                    chk("start_opcode", 32'(eu_opcode), 32'(held.op));
                    chk("start_a", 32'(eu_a), 32'(held.a));
                    chk("start_b", 32'(eu_b), 32'(held.b));
                    inflight = 1;
                end
            end else if (inflight && !rsp_valid) begin
                chk("hold_opcode", 32'(eu_opcode), 32'(held.op));
                chk("hold_a", 32'(eu_a), 32'(held.a));
                chk("hold_b", 32'(eu_b), 32'(held.b));
            end
            if (rsp_valid) begin
                inflight = 0;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp actual=valid required=idle tag=%0d (cycle %0d)", rsp_tag, cyc);
                end else begin
                    chk("rsp_result", 32'(rsp_result), 32'(exp_q[0].res));
                    chk("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
                    chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                    if (rsp_ready) begin
                        $display("RSP tag=%0d result=%04h err=%0d cycle=%0d", rsp_tag, rsp_result, rsp_err, cyc);
                        tag_log.push_back(rsp_tag);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (start/end at posedge+1) ----------------
    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [TAG_W-1:0] tag, output int acc_cyc);
        int n;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout actual=not_accepted required=accepted tag=%0d", tag);
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 300);
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout actual=no_rsp required=rsp_valid");
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!eu_start && n < 300);
        if (!eu_start) begin
            checks++; errors++;
            $display("FAIL start_timeout actual=no_start required=eu_start");
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals();
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_eu_start", 32'(eu_start), 32'd0);
        chk("rst_eu_opcode", 32'(eu_opcode), 32'd0);
        chk("rst_eu_a", 32'(eu_a), 32'd0);
        chk("rst_eu_b", 32'(eu_b), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t_acc, s0;
        logic [TAG_W-1:0] exp_tags[6];

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_vals();

        // Basic ADD: start at N+2, response the cycle after done.
        eu_lat = 1;
        push(4'd0, 8'd3, 8'd4, 4'd2, t_acc);
        wait_rsp();
        chk("add_start_cycle", 32'(last_start_cyc), 32'(t_acc + 2));
        chk("add_rsp_after_done", 32'(cyc), 32'(done_cyc + 1));
        chk("add_rsp_cycle", 32'(cyc), 32'(t_acc + 4));
        chk("add_result", 32'(rsp_result), 32'h0007);
        chk("add_tag", 32'(rsp_tag), 32'd2);
        chk("add_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        drain();

        // Fill the FIFO behind a slow operation; next push must stall.
        eu_lat = 8;
        tag_log.delete();
        push(4'd0, 8'd1, 8'd1, 4'd1, t_acc);
        wait_start();
        push(4'd0, 8'd10, 8'd11, 4'd3, t_acc);
        push(4'd8, 8'd12, 8'd13, 4'd4, t_acc);
        push(4'd1, 8'd50, 8'd7, 4'd5, t_acc);
        push(4'd9, 8'd90, 8'd9, 4'd6, t_acc);
        cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_a = 8'd2; cmd_b = 8'd2; cmd_tag = 4'd7;
        @(negedge clk);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        push(4'd0, 8'd2, 8'd2, 4'd7, t_acc);
        drain();
        exp_tags = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        chk("order_count", 32'(tag_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < tag_log.size(); i++)
            chk("order_tag", 32'(tag_log[i]), 32'(exp_tags[i]));

        // Illegal opcode: answered locally, never issued.
        s0 = start_cnt;
        push(4'hC, 8'd1, 8'd2, 4'd5, t_acc);
        wait_rsp();
        chk("illegal_result", 32'(rsp_result), 32'd0);
        chk("illegal_err", 32'(rsp_err), 32'd1);
        chk("illegal_tag", 32'(rsp_tag), 32'd5);
        chk("illegal_no_start", 32'(start_cnt), 32'(s0));
        @(posedge clk); #1;
        drain();

        // Timeout: error exactly TIMEOUT cycles after entering WAIT.
        s0 = start_cnt;
        push(4'd7, 8'hEE, 8'd0, 4'd6, t_acc);
        push(4'd0, 8'd10, 8'd20, 4'd7, t_acc);
        wait_rsp();
        chk("timeout_cycle", 32'(cyc), 32'(last_start_cyc + 1 + TIMEOUT));
        chk("timeout_result", 32'(rsp_result), 32'd0);
        chk("timeout_err", 32'(rsp_err), 32'd1);
        chk("timeout_tag", 32'(rsp_tag), 32'd6);
        @(posedge clk); #1;
        drain();
        chk("timeout_next_issued", 32'(start_cnt - s0), 32'd2);

        // Divide by zero.
        s0 = start_cnt;
        push(4'd9, 8'd20, 8'd0, 4'd8, t_acc);
        wait_rsp();
        chk("div0_tag", 32'(rsp_tag), 32'd8);
`ifdef DIVZERO_TRAP_EN
        chk("div0_starts", 32'(start_cnt - s0), 32'd0);
        chk("div0_err", 32'(rsp_err), 32'd1);
        chk("div0_result", 32'(rsp_result), 32'd0);
`else
        chk("div0_starts", 32'(start_cnt - s0), 32'd1);
        chk("div0_err", 32'(rsp_err), 32'd0);
        chk("div0_result", 32'(rsp_result), 32'hFFFF);
`endif
        @(posedge clk); #1;
        drain();

        // Response back-pressure, then reset in WAIT while the unit is busy.
        eu_lat = 1;
        rsp_ready = 1'b0;
        push(4'd1, 8'd9, 8'd2, 4'd9, t_acc);
        wait_rsp();
        repeat (10) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_tag", 32'(rsp_tag), 32'd9);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain();
        eu_lat = 40;
        push(4'd8, 8'd5, 8'd6, 4'd10, t_acc);
        push(4'd0, 8'd1, 8'd1, 4'd11, t_acc);
        wait_start();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        iss_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset_vals();
        eu_lat = 1;
        push(4'd2, 8'd5, 8'd5, 4'd12, t_acc);
        wait_rsp();
        chk("post_rst_issue_after_busy", 32'(last_start_cyc), 32'(busy_fall_cyc + 1));
        chk("post_rst_tag", 32'(rsp_tag), 32'd12);
        @(posedge clk); #1;
        drain();

        // Randomized traffic with random latency and back-pressure.
        eu_lat_rand = 1;
        for (int i = 0; i < 500; i++) begin
            cmd_valid  = ($urandom_range(0, 2) != 0);
            cmd_opcode = 4'($urandom_range(0, 15));
            cmd_a      = 8'($urandom);
            cmd_b      = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            cmd_tag    = 4'($urandom);
            if ($urandom_range(0, 60) == 0) begin
                cmd_opcode = 4'd7; cmd_a = 8'hEE;
            end
            rsp_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        chk("final_iss_empty", 32'(iss_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eu_dispatch.md
# eu_dispatch

Command front end for the execution unit: buffers operation requests in a small FIFO, issues them one at a time to the execution unit with a single-cycle start pulse, and holds operands and opcode stable until the unit reports done. It then presents the 16-bit result with its tag on a valid/ready response port. It sits directly upstream of the execution unit, and its response port feeds writeback.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- TAG_W, 4: width of the command tag returned with each response.
- TIMEOUT, 64: maximum cycles in WAIT before the operation is aborted with an error; ≥20.

Ports:
- clk  in  1  sole clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full; transfer occurs when cmd_valid && cmd_ready.
- cmd_opcode  in  4  operation: 0–7 ALU, 8 MUL, 9 DIV, 10–15 illegal.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_tag  in  TAG_W  caller tag, echoed on the response.
- eu_start  out  1  one-cycle start pulse to the execution unit.
- eu_opcode  out  4  opcode to the execution unit; stable from ISSUE through WAIT.
- eu_a  out  8  operand A to the execution unit; same stability rule.
- eu_b  out  8  operand B to the execution unit; same stability rule.
- eu_busy  in  1  execution unit busy.
- eu_done  in  1  execution unit done pulse.
- eu_result  in  16  execution unit result; sampled only while eu_done=1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  downstream accepts the response.
- rsp_result  out  16  captured result.
- rsp_tag  out  TAG_W  tag of the completed command.
- rsp_err  out  1  illegal opcode, timeout, or divide-by-zero (divide-by-zero only when DIVZERO_TRAP_EN is compiled in).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty and eu_busy=0: pop the head into the op registers (opcode, a, b, tag).
  - If the popped opcode is greater than 9: load rsp_result=0 and rsp_err=1, go to RESP.
  - Otherwise go to ISSUE.
  - Stay in IDLE while eu_busy=1. This protects against an operation left in flight by a reset, because the execution unit has no reset.
- ISSUE: eu_start=1 for exactly this cycle, clear the timer, go to WAIT.
- WAIT:
  - On eu_done=1: rsp_result←eu_result, rsp_err←0, go to RESP.
  - Otherwise increment the timer. When the timer reaches TIMEOUT−1: rsp_result←0, rsp_err←1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_result, rsp_tag and rsp_err are held stable.
  - On rsp_ready=1, go to IDLE.
- eu_done is ignored in every state except WAIT.
- FIFO behaviour:
  - Push and pop in the same cycle are both permitted.
  - When full, cmd_ready=0 and no push occurs.
  - A pop when empty never happens.
  - Pointers are log2(DEPTH)+1 bits wide with wrap bit; full/empty are decided by comparing pointers.
- Command order is strictly preserved. At most one operation is outstanding.

## Timing
- Reset values: cmd_ready=1, eu_start=0, eu_opcode/eu_a/eu_b=0, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_err=0. State returns to IDLE, FIFO is emptied, timer is cleared.
- Reset mid-operation discards the in-flight command and all queued commands.
- Command accepted at cycle N into an empty FIFO with the unit idle:
  - pop at N+1;
  - eu_start at N+2;
  - rsp_valid in the cycle after eu_done.
- The minimum spacing between two eu_start pulses is 4 cycles.
- rsp_valid stays high until the rsp_ready handshake completes; it may stay high indefinitely.

## Configuration
- DIVZERO_TRAP_EN defined:
  - In IDLE, a popped opcode 9 with operand b=0 is not issued.
  - rsp_result=0, rsp_err=1, go directly to RESP.
- DIVZERO_TRAP_EN undefined: DIV by zero is issued normally, and the result is whatever the divider returns.

## Structure
- Shared package eu_pkg holds:
  - opcode constants: OP_MUL=4'h8, OP_DIV=4'h9, OP_MAX_LEGAL=4'h9;
  - the FSM state enum;
  - result width constant RES_W=16.
- One sub-module, eu_cmd_fifo: parameterised DEPTH and width (4+8+8+TAG_W), with push/pop/full/empty.

## Test plan
- Reset, then push ADD (opcode 0) with A=3, B=4, tag=2; model unit returns done 1 cycle after start with 16'h0007 -> eu_start at N+2; rsp_valid with result 0x0007, tag 2, err 0.
- Push 4 commands back-to-back while the unit takes 8 cycles each -> 5th push sees cmd_ready=0; responses return in tag order; eu_start never fires while eu_busy=1.
- Push opcode 4'hC, tag 5 -> no eu_start; rsp_valid with result 0, err 1, tag 5.
- Model never asserts done -> rsp_err=1 exactly TIMEOUT cycles after entering WAIT; the next queued command issues normally.
- DIV with A=20, B=0: with DIVZERO_TRAP_EN defined -> err 1, no eu_start; without it -> eu_start fires and err 0.
- Hold rsp_ready=0 for 10 cycles, then assert rst while in WAIT with eu_busy=1 -> outputs take reset values, and no issue occurs until eu_busy falls.
